// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler with HI/LO registers.
// Computes the result as soon as an op is accepted and parks it in a pending
// register. A busy counter then models the fixed latency before HI/LO change.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [1:0]  E_op,
  input  logic [31:0] E_a,
  input  logic [31:0] E_b,
  input  logic        E_hiwe,
  input  logic        E_lowe,
  input  logic        D_mduuse,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load, done;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   res_hi, res_lo;

  // Multiply: one 64x64 multiplier; extension mode selects signed/unsigned.
  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  // Divide: magnitude divide, then fix signs (quotient toward zero,
  // remainder takes the dividend's sign). 0x80000000/-1 falls out naturally.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_m, r_m, quot, rem;

  // Result datapath for the op currently presented in E.
  always_comb begin
    sgn    = ~E_op[0];
    ext_a  = {{32{sgn & E_a[31]}}, E_a};
    ext_b  = {{32{sgn & E_b[31]}}, E_b};
    prod   = ext_a * ext_b;
    neg_a  = sgn & E_a[31];
    neg_b  = sgn & E_b[31];
    mag_a  = neg_a ? -E_a : E_a;
    mag_b  = neg_b ? -E_b : E_b;
    q_m    = mag_a / mag_b;
    r_m    = mag_a % mag_b;
    quot   = (neg_a ^ neg_b) ? -q_m : q_m;
    rem    = neg_a ? -r_m : r_m;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (E_op[1]) begin
      // Divide by zero still burns the cycles but leaves HI/LO as they are.
      res_hi = (E_b == '0) ? hi : rem;
      res_lo = (E_b == '0) ? lo : quot;
    end
  end

  // Next-state logic: load the latency counter on accept, finish at cnt==1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (E_start) begin
        load    = 1'b1;
        cnt_n   = E_op[1] ? DC : MC;
        state_n = BUSY;
      end
      BUSY: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          done    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // HI/LO and pending result; mthi/mtlo only act when idle and not starting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      hi_n <= '0;
      lo_n <= '0;
    end else if (load) begin
      hi_n <= res_hi;
      lo_n <= res_lo;
    end else if (done) begin
      hi <= hi_n;
      lo <= lo_n;
    end else if (state == IDLE) begin
      if (E_hiwe) hi <= E_a;
      if (E_lowe) lo <= E_a;
    end
  end

  assign busy  = (state == BUSY);
  assign stall = D_mduuse & (busy | E_start);

  // The hazard unit must keep new MDU instructions out of E while busy.
  a_no_issue_busy: assert property (@(posedge clk) disable iff (reset)
    busy |-> !(E_start || E_hiwe || E_lowe));
endmodule
